// File: rtl/rv_bht_predict.sv
// Tagged branch history table: combinational direction/target prediction in ID,
// counter/target training from EX, one-cycle registered mispredict flush.
module rv_bht_entry #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic             taken_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [XLEN-1:0]  target_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [XLEN-1:0]  tgt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_ONE << (CNT_W-1);
  localparam logic [CNT_W-1:0] CNT_WN  = CNT_WT - CNT_ONE;

  logic             vld_q, vld_d, hit;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    hit   = vld_q && (tag_q == tag_i);
    // clear dominates any same-cycle training of this entry
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (wr_i) begin
      if (hit) begin
        if (taken_i && cnt_q != CNT_MAX)     cnt_d = cnt_q + CNT_ONE;
        else if (!taken_i && cnt_q != '0)    cnt_d = cnt_q - CNT_ONE;
      end else begin
        vld_d = 1'b1;
        tag_d = tag_i;
        cnt_d = taken_i ? CNT_WT : CNT_WN;
      end
      if (taken_i) tgt_d = target_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      tag_q <= '0;
      cnt_q <= CNT_WN;
      tgt_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

  assign vld_o = vld_q;
  assign tag_o = tag_q;
  assign cnt_o = cnt_q;
  assign tgt_o = tgt_q;
endmodule

module rv_bht_predict #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] lk_pc_i,
  input  logic            lk_branch_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            up_valid_i,
  input  logic [XLEN-1:0] up_pc_i,
  input  logic            up_taken_i,
  input  logic [XLEN-1:0] up_target_i,
  input  logic            up_pred_i,
  input  logic            clr_i,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     mis_cnt_o
);
  localparam int DEPTH = 1 << IDX_W;

  logic [IDX_W-1:0]                 lk_idx, up_idx;
  logic [TAG_W-1:0]                 lk_tag, up_tag;
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][TAG_W-1:0]      ent_tag;
  logic [DEPTH-1:0][CNT_W-1:0]      ent_cnt;
  logic [DEPTH-1:0][XLEN-1:0]       ent_tgt;
  logic                             mispred;
  logic                             flush_q, flush_d;
  logic [XLEN-1:0]                  redir_q, redir_d;
  logic [31:0]                      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  assign lk_idx = lk_pc_i[IDX_W+1:2];
  assign lk_tag = lk_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = up_pc_i[IDX_W+1:2];
  assign up_tag = up_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rv_bht_entry #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_ent (
      .clk      (clk),
      .rstn     (rstn),
      .clr_i    (clr_i),
      .wr_i     (up_valid_i && (up_idx == IDX_W'(g))),
      .taken_i  (up_taken_i),
      .tag_i    (up_tag),
      .target_i (up_target_i),
      .vld_o    (ent_vld[g]),
      .tag_o    (ent_tag[g]),
      .cnt_o    (ent_cnt[g]),
      .tgt_o    (ent_tgt[g])
    );
  end

  // reads the registered table directly, so a same-cycle update is not visible
  assign pred_taken_o  = lk_branch_i && ent_vld[lk_idx] && (ent_tag[lk_idx] == lk_tag)
                         && ent_cnt[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? ent_tgt[lk_idx] : lk_pc_i + XLEN'(4);

  assign mispred = up_valid_i && (up_taken_i != up_pred_i);

  always_comb begin
    flush_d   = mispred;
    redir_d   = redir_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (mispred)                          redir_d   = up_taken_i ? up_target_i : up_pc_i + XLEN'(4);
    if (up_valid_i && br_cnt_q != '1)     br_cnt_d  = br_cnt_q + 32'd1;
    if (mispred && mis_cnt_q != '1)       mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_q   <= 1'b0;
      redir_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      flush_q   <= flush_d;
      redir_q   <= redir_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign flush_o       = flush_q;
  assign redirect_pc_o = redir_q;
  assign br_cnt_o      = br_cnt_q;
  assign mis_cnt_o     = mis_cnt_q;
endmodule

// File: doc/rv_bht_predict.md
RV_BHT_PREDICT -- requirements
Module: rv_bht_predict

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the PC/target width.
REQ-002 SHALL have parameter IDX_W, default 4, meaning log2 of table depth (2^IDX_W entries).
REQ-003 SHALL have parameter TAG_W, default 8, meaning tag bits stored per entry.
REQ-004 SHALL have parameter CNT_W, default 2, meaning saturating counter width (legal range 1..4).
REQ-005 SHALL have port clk, input, 1, the single clock; all state SHALL change on posedge clk.
REQ-006 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port lk_pc_i, input, XLEN, the PC of the branch in ID to look up.
REQ-008 SHALL have port lk_branch_i, input, 1, asserted when the ID instruction is a conditional branch.
REQ-009 SHALL have port pred_taken_o, output, 1, combinational taken prediction.
REQ-010 SHALL have port pred_target_o, output, XLEN, combinational predicted target.
REQ-011 SHALL have port up_valid_i, input, 1, a resolved branch is in EX this cycle.
REQ-012 SHALL have port up_pc_i, input, XLEN, the resolved branch PC.
REQ-013 SHALL have port up_taken_i, input, 1, the actual direction.
REQ-014 SHALL have port up_target_i, input, XLEN, the actual taken target.
REQ-015 SHALL have port up_pred_i, input, 1, the prediction made for this branch in ID.
REQ-016 SHALL have port clr_i, input, 1, synchronous invalidation of all entries.
REQ-017 SHALL have port flush_o, output, 1, registered mispredict flush request.
REQ-018 SHALL have port redirect_pc_o, output, XLEN, registered correct fetch PC, valid while flush_o=1.
REQ-019 SHALL have ports br_cnt_o and mis_cnt_o, output, 32 each, resolved-branch and mispredict counts.

Function
REQ-020 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-021 Each entry SHALL hold valid, tag, CNT_W-bit counter and XLEN-bit target.
REQ-022 pred_taken_o SHALL be 1 only when lk_branch_i=1, the entry is valid, its tag matches, and counter MSB=1; otherwise 0.
REQ-023 pred_target_o SHALL equal the entry target when pred_taken_o=1, else lk_pc_i+4.
REQ-024 On up_valid_i with a tag hit, the counter SHALL increment when taken and decrement when not taken, saturating at 2^CNT_W-1 and 0.
REQ-025 On up_valid_i with a miss, the entry SHALL be allocated: valid=1, tag written, counter=2^(CNT_W-1) if taken, else 2^(CNT_W-1)-1.
REQ-026 On any update with up_taken_i=1, the target SHALL be written with up_target_i; not-taken updates SHALL leave the target unchanged.
REQ-027 A lookup and update to the same index in one cycle SHALL return pre-update contents, with no bypass.
REQ-028 A mispredict is up_valid_i & (up_taken_i != up_pred_i). It SHALL set flush_o=1 on the next cycle for exactly one cycle per mispredict.
REQ-029 On mispredict, redirect_pc_o SHALL be up_target_i if taken, else up_pc_i+4. Both addition and index arithmetic SHALL wrap modulo 2^XLEN.
REQ-030 br_cnt_o SHALL increment on each up_valid_i. mis_cnt_o SHALL increment on each mispredict. Both SHALL saturate at 32'hFFFF_FFFF.
REQ-031 clr_i SHALL clear all valid bits next edge. If asserted with up_valid_i, the clear SHALL win for the table, but flush_o and the counters SHALL still update.
REQ-032 Table and counter updates SHALL take effect one cycle after the update cycle; predictions are combinational (zero latency).

Reset
REQ-033 While rstn=0: all valid bits=0, counters=2^(CNT_W-1)-1, targets=0, flush_o=0, redirect_pc_o=0, br_cnt_o=0, mis_cnt_o=0.
REQ-034 Reset asserted mid-operation SHALL discard any pending flush immediately and asynchronously.

Verification
REQ-035 After reset, lk_branch_i=1, lk_pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104.
REQ-036 Update pc=0x100, taken, target=0x80, up_pred_i=0 -> next cycle flush_o=1, redirect_pc_o=0x80, mis_cnt_o=1. Lookup 0x100 -> taken, target 0x80.
REQ-037 Three further taken updates at 0x100 -> counter=3 (saturated). Then one not-taken -> still predicts taken. A second not-taken -> predicts not taken.
REQ-038 Alias 0x140 (same index, different tag) after training 0x100 -> lookup 0x140 misses, pred_taken_o=0. Update 0x140 not-taken -> 0x100 entry replaced.
REQ-039 Same-cycle lookup and update at 0x100 -> lookup returns the old counter. clr_i with up_valid_i -> table empty next cycle, br_cnt_o still incremented.
REQ-040 Assert rstn=0 in the cycle flush_o=1 -> flush_o=0 immediately, all counts=0.
